// File: rtl/vga_pkg.sv
// Shared VGA timing constants, colour types and the colour-bar table used by
// the scanout (read side) and vga_plot (write side) of the framebuffer.
package vga_pkg;

    localparam int H_ACTIVE   = 640;
    localparam int H_FP       = 16;
    localparam int H_SYNC     = 96;
    localparam int H_BP       = 48;
    localparam int H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_ACTIVE   = 480;
    localparam int V_FP       = 10;
    localparam int V_SYNC     = 2;
    localparam int V_BP       = 33;
    localparam int V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int CNT_W      = 10;
    localparam int COLOUR_W   = 12;
    localparam int FB_WIDTH   = 160;
    localparam int SCALE_LOG2 = 2;
    localparam int ADDR_W     = 15;
    localparam int BAR_WIDTH  = H_ACTIVE / 8;

    typedef logic [COLOUR_W-1:0] colour_t;

    localparam colour_t COLOUR_BACKGROUND = 12'h222;
    localparam colour_t COLOUR_NEEDLE     = 12'hC38;

    // Everything stage 0 captures about one pixel, carried to the pin stage.
    typedef struct packed {
        logic    hs;
        logic    vs;
        logic    active;
        logic    vblank;
        logic    frame_start;
        logic    pattern;
        colour_t bar;
    } stage_t;

    localparam stage_t STAGE_RESET = '{hs: 1'b1, vs: 1'b1, default: '0};

    function automatic colour_t bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    return 12'hFFF;
            3'd1:    return 12'hFF0;
            3'd2:    return 12'h0FF;
            3'd3:    return 12'h0F0;
            3'd4:    return 12'hF0F;
            3'd5:    return 12'hF00;
            3'd6:    return 12'h00F;
            default: return 12'h000;
        endcase
    endfunction

    // hcount / BAR_WIDTH without a divider; only meaningful inside the active line.
    function automatic logic [2:0] bar_index(input logic [CNT_W-1:0] h);
        logic [2:0] idx;
        idx = '0;
        for (int i = 1; i < 8; i++) begin
            if (h >= CNT_W'(i * BAR_WIDTH)) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/vga_timing.sv
// Pixel-enable divider, raster counters and raw (undelayed) sync/blank decode.
module vga_timing #(
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int H_FP     = vga_pkg::H_FP,
    parameter int H_SYNC   = vga_pkg::H_SYNC,
    parameter int H_BP     = vga_pkg::H_BP,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int V_FP     = vga_pkg::V_FP,
    parameter int V_SYNC   = vga_pkg::V_SYNC,
    parameter int V_BP     = vga_pkg::V_BP
) (
    input  logic                      clock_i,
    input  logic                      resetn_i,
    output logic                      pix_en_o,
    output logic [vga_pkg::CNT_W-1:0] hcount_o,
    output logic [vga_pkg::CNT_W-1:0] vcount_o,
    output logic                      hs_o,
    output logic                      vs_o,
    output logic                      active_o,
    output logic                      vblank_o,
    output logic                      frame_o
);
    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    import vga_pkg::*;

    logic             pix_en_q;
    logic [CNT_W-1:0] hcount_q, hcount_d;
    logic [CNT_W-1:0] vcount_q, vcount_d;

    always_comb begin
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        if (pix_en_q) begin
            if (hcount_q == CNT_W'(H_TOT - 1)) begin
                hcount_d = '0;
                vcount_d = (vcount_q == CNT_W'(V_TOT - 1)) ? '0 : vcount_q + 1'b1;
            end else begin
                hcount_d = hcount_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            pix_en_q <= 1'b0;
            hcount_q <= '0;
            vcount_q <= '0;
        end else begin
            pix_en_q <= ~pix_en_q;
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
        end
    end

    assign pix_en_o = pix_en_q;
    assign hcount_o = hcount_q;
    assign vcount_o = vcount_q;
    assign hs_o     = !((hcount_q >= CNT_W'(H_ACTIVE + H_FP)) &&
                        (hcount_q <  CNT_W'(H_ACTIVE + H_FP + H_SYNC)));
    assign vs_o     = !((vcount_q >= CNT_W'(V_ACTIVE + V_FP)) &&
                        (vcount_q <  CNT_W'(V_ACTIVE + V_FP + V_SYNC)));
    assign active_o = (hcount_q < CNT_W'(H_ACTIVE)) && (vcount_q < CNT_W'(V_ACTIVE));
    assign vblank_o = (vcount_q >= CNT_W'(V_ACTIVE));
    assign frame_o  = (vcount_q == CNT_W'(V_ACTIVE)) && (hcount_q == '0);

endmodule

// File: rtl/vga_scanout.sv
// Framebuffer read side: address generation, 2-tick data/sync pipeline and
// the DAC/connector pins. Pins lag the raster counters by exactly 2 ticks.
module vga_scanout #(
    parameter int H_ACTIVE   = vga_pkg::H_ACTIVE,
    parameter int H_FP       = vga_pkg::H_FP,
    parameter int H_SYNC     = vga_pkg::H_SYNC,
    parameter int H_BP       = vga_pkg::H_BP,
    parameter int V_ACTIVE   = vga_pkg::V_ACTIVE,
    parameter int V_FP       = vga_pkg::V_FP,
    parameter int V_SYNC     = vga_pkg::V_SYNC,
    parameter int V_BP       = vga_pkg::V_BP,
    parameter int FB_WIDTH   = vga_pkg::FB_WIDTH,
    parameter int SCALE_LOG2 = vga_pkg::SCALE_LOG2,
    parameter int ADDR_W     = vga_pkg::ADDR_W
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              PatternEn,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [11:0]       rd_data,
    output logic [3:0]        VGA_R,
    output logic [3:0]        VGA_G,
    output logic [3:0]        VGA_B,
    output logic              VGA_HS,
    output logic              VGA_VS,
    output logic              VGA_BLANK_N,
    output logic              VGA_CLK,
    output logic              InVBlank,
    output logic              FrameStart
);
    import vga_pkg::*;

    logic             pix_en;
    logic [CNT_W-1:0] hcount, vcount;
    logic             hs_raw, vs_raw, active_raw, vblank_raw, frame_raw;

    vga_timing #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_timing (
        .clock_i  (Clock),
        .resetn_i (Resetn),
        .pix_en_o (pix_en),
        .hcount_o (hcount),
        .vcount_o (vcount),
        .hs_o     (hs_raw),
        .vs_o     (vs_raw),
        .active_o (active_raw),
        .vblank_o (vblank_raw),
        .frame_o  (frame_raw)
    );

    logic [ADDR_W-1:0] fb_x, fb_y, addr_calc;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    stage_t            s1_q, s1_d;
    colour_t           rgb_q, rgb_d;
    logic              hs_q, vs_q, blank_n_q, vblank_q, frame_q, vga_clk_q;

    assign fb_x = ADDR_W'(hcount >> SCALE_LOG2);
    assign fb_y = ADDR_W'(vcount >> SCALE_LOG2);

    generate
        if (FB_WIDTH == 160) begin : g_shift_add
            assign addr_calc = (fb_y << 7) + (fb_y << 5) + fb_x;
        end else begin : g_mult
            assign addr_calc = ADDR_W'(fb_y * FB_WIDTH) + fb_x;
        end
    endgenerate

    always_comb begin
        s1_d = '{hs: hs_raw, vs: vs_raw, active: active_raw, vblank: vblank_raw,
                 frame_start: frame_raw, pattern: PatternEn,
                 bar: bar_colour(bar_index(hcount))};
        // Address only moves in the active area; during blanking it is a don't-care.
        rd_addr_d = active_raw ? addr_calc : rd_addr_q;
        rgb_d     = '0;
        if (s1_q.active) rgb_d = s1_q.pattern ? s1_q.bar : rd_data;
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            s1_q      <= STAGE_RESET;
            rd_addr_q <= '0;
            rgb_q     <= '0;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            blank_n_q <= 1'b0;
            vblank_q  <= 1'b0;
            frame_q   <= 1'b0;
            vga_clk_q <= 1'b0;
        end else begin
            vga_clk_q <= ~pix_en;
            // Single-Clock pulse on the tick that puts line V_ACTIVE, column 0 on the pins.
            frame_q   <= pix_en & s1_q.frame_start;
            if (pix_en) begin
                s1_q      <= s1_d;
                rd_addr_q <= rd_addr_d;
                rgb_q     <= rgb_d;
                hs_q      <= s1_q.hs;
                vs_q      <= s1_q.vs;
                blank_n_q <= s1_q.active;
                vblank_q  <= s1_q.vblank;
            end
        end
    end

    assign rd_addr     = rd_addr_q;
    assign VGA_R       = rgb_q[11:8];
    assign VGA_G       = rgb_q[7:4];
    assign VGA_B       = rgb_q[3:0];
    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;
    assign VGA_BLANK_N = blank_n_q;
    assign VGA_CLK     = vga_clk_q;
    assign InVBlank    = vblank_q;
    assign FrameStart  = frame_q;

endmodule
